// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader and the multicycle
// MIPS core it feeds.
//   - state_t     : loader FSM encoding (HDR, DATA, CSUM, DONE, ERR)
//   - IMEM_DEPTH  : default instruction memory depth in words
//   - WORD_W      : instruction width (always four bytes)
//   - OP_*        : primary opcode values decoded by the core
package loader_pkg;

    localparam int unsigned IMEM_DEPTH = 16;
    localparam int unsigned WORD_W     = 32;

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        DATA = 3'd1,
        CSUM = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    // Primary opcodes (instr[31:26]) understood by the core.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    function automatic logic [5:0] opcode_of(input logic [WORD_W-1:0] instr);
        return instr[WORD_W-1 -: 6];
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Packs an MSB-first byte stream into instruction words and keeps a running
// XOR of every byte it absorbs.
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : restart a frame (byte count and checksum back to zero)
//   byte_en     : absorb byte_in this cycle
//   byte_in     : payload byte
//   word_done   : combinational, this byte completes a word
//   word_ready  : one-cycle pulse the cycle after a word completes
//   word_out    : completed word, held until the next word completes
//   csum        : XOR of all bytes absorbed since the last clear
module byte_assembler #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic              word_done,
    output logic              word_ready,
    output logic [WORD_W-1:0] word_out,
    output logic [7:0]        csum
);

    // Only the first three bytes of a word need holding; the fourth goes
    // straight into word_out.
    logic [WORD_W-9:0] shift_q;
    logic [1:0]        byte_cnt;

    assign word_done = byte_en && (byte_cnt == 2'd3);

    // word_out is a separate buffer from shift_q, so the next word can start
    // shifting in during the cycle the previous one is being written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            byte_cnt   <= '0;
            csum       <= '0;
            word_out   <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= 1'b0;
            if (clear) begin
                shift_q  <= '0;
                byte_cnt <= '0;
                csum     <= '0;
            end else if (byte_en) begin
                shift_q  <= {shift_q[WORD_W-17:0], byte_in};
                csum     <= csum ^ byte_in;
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    word_out   <= {shift_q, byte_in};
                    word_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a program frame [N][4*N payload bytes][C] into instruction memory and
// starts the core when the trailing XOR checksum matches.
// Handshake: a byte moves on a rising edge where byte_valid and byte_ready
// are both 1; byte_valid may be held or dropped freely and the loader waits
// indefinitely; byte_ready is a register and never depends on byte_valid.
//   clk, rst      : clock, asynchronous active-high reset
//   byte_in/valid : stream byte and its valid
//   byte_ready    : 1 in HDR, DATA and CSUM
//   reload        : pulse, returns DONE/ERR to HDR
//   imem_we/waddr/wdata : one write strobe per assembled word
//   words_loaded  : words written in the current frame
//   core_start    : one-cycle pulse on a good load
//   done, err     : sticky status levels
//   state_dbg     : current FSM state
module imem_loader #(
    parameter int unsigned IMEM_DEPTH = loader_pkg::IMEM_DEPTH,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned WORD_W     = loader_pkg::WORD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    input  logic                reload,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_waddr,
    output logic [WORD_W-1:0]   imem_wdata,
    output logic [ADDR_W:0]     words_loaded,
    output logic                core_start,
    output logic                done,
    output logic                err,
    output loader_pkg::state_t  state_dbg
);

    import loader_pkg::*;

    state_t          state, state_next;
    logic            accept;
    logic            hdr_bad;
    logic            payload_done;
    logic            latch_n;
    logic [ADDR_W:0] n_words;

    logic            asm_clear;
    logic            asm_en;
    logic            asm_word_done;
    logic [7:0]      asm_csum;

    assign accept    = byte_valid & byte_ready;
    assign hdr_bad   = (byte_in == 8'd0) || (32'(byte_in) > IMEM_DEPTH);
    assign state_dbg = state;

    // words_loaded doubles as the write index. In DATA it only equals N
    // during the write cycle of the last word.
    assign payload_done = (words_loaded == n_words);

    byte_assembler #(.WORD_W(WORD_W)) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_en    (asm_en),
        .byte_in    (byte_in),
        .word_done  (asm_word_done),
        .word_ready (imem_we),
        .word_out   (imem_wdata),
        .csum       (asm_csum)
    );

    always_comb begin
        state_next = state;
        asm_clear  = 1'b0;
        asm_en     = 1'b0;
        latch_n    = 1'b0;
        unique case (state)
            HDR: begin
                if (accept) begin
                    if (hdr_bad) begin
                        state_next = ERR;
                    end else begin
                        state_next = DATA;
                        asm_clear  = 1'b1;
                        latch_n    = 1'b1;
                    end
                end
            end
            DATA: begin
                // A byte arriving in the last word's write cycle is already
                // the checksum: judge it here so the stream never stalls.
                if (accept && payload_done) begin
                    state_next = (byte_in == asm_csum) ? DONE : ERR;
                end else if (accept) begin
                    asm_en = 1'b1;
                end else if (payload_done) begin
                    state_next = CSUM;
                end
            end
            CSUM: begin
                if (accept) begin
                    state_next = (byte_in == asm_csum) ? DONE : ERR;
                end
            end
            DONE, ERR: begin
                if (reload) begin
                    state_next = HDR;
                    asm_clear  = 1'b1;
                end
            end
            default: state_next = HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= HDR;
            byte_ready   <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            core_start   <= 1'b0;
            n_words      <= '0;
            words_loaded <= '0;
            imem_waddr   <= '0;
        end else begin
            state      <= state_next;
            byte_ready <= (state_next == HDR) || (state_next == DATA) ||
                          (state_next == CSUM);
            done       <= (state_next == DONE);
            err        <= (state_next == ERR);
            core_start <= (state_next == DONE) && (state != DONE);
            if (latch_n) begin
                n_words <= byte_in[ADDR_W:0];
            end
            if (asm_clear) begin
                words_loaded <= '0;
            end else if (asm_word_done) begin
                imem_waddr   <= words_loaded[ADDR_W-1:0];
                words_loaded <= words_loaded + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  import loader_pkg::*;

  localparam int ADDR_W = 4;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 16;
  localparam int LW     = ADDR_W + WORD_W;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_valid = 1'b0;
  logic              reload = 1'b0;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [WORD_W-1:0] imem_wdata;
  logic [ADDR_W:0]   words_loaded;
  logic              core_start;
  logic              done;
  logic              err;
  state_t            state_dbg;

  always #5 clk = ~clk;

  imem_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .words_loaded (words_loaded),
    .core_start   (core_start),
    .done         (done),
    .err          (err),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] wr_log[$];
  logic [7:0]  frame_q[$];
  int          start_cnt = 0;
  int          stall_cnt = 0;
  int          timeouts = 0;
  logic        exp_done;
  logic        exp_err;
  logic [ADDR_W:0] exp_words;

  // Observed write and start activity, sampled away from the active edge.
  always @(negedge clk) begin
    if (imem_we) wr_log.push_back({imem_waddr, imem_wdata});
    if (core_start) start_cnt++;
  end

  // ---------------- reference model ----------------
  // Frame meaning: N words, each four bytes MSB first, then the XOR of all
  // payload bytes. Bad N means nothing but the header is consumed.
  function automatic void model_frame();
    int n;
    logic [7:0] x;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err = 1'b0;
    exp_words = '0;
    x = 8'h00;
    n = int'(frame_q[0]);
    if (n == 0 || n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      exp_q.push_back({ADDR_W'(w), frame_q[1+4*w], frame_q[2+4*w],
                       frame_q[3+4*w], frame_q[4+4*w]});
      for (int b = 1; b <= 4; b++) x = x ^ frame_q[4*w+b];
    end
    exp_words = (ADDR_W+1)'(n);
    if (frame_q[4*n+1] == x) exp_done = 1'b1;
    else exp_err = 1'b1;
  endfunction

  function automatic void random_frame(input int n, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    frame_q.delete();
    frame_q.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom_range(0, 255));
      frame_q.push_back(b);
      x = x ^ b;
    end
    if (corrupt) x = x ^ (8'h01 << $urandom_range(0, 7));
    frame_q.push_back(x);
  endfunction

  // ---------------- driver tasks ----------------
  // Entered and left #1 after a rising edge; byte_valid stays high on exit
  // so a following call with gap 0 streams back to back.
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    bit r;
    ok = 1'b0;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    byte_in = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      r = byte_ready;
      @(posedge clk); #1;
      if (r) begin ok = 1'b1; break; end
      stall_cnt++;
    end
  endtask

  task automatic send_frame(input int gap_max);
    bit ok;
    timeouts = 0;
    foreach (frame_q[i]) begin
      send_byte(frame_q[i], $urandom_range(0, gap_max), ok);
      if (!ok) timeouts++;
    end
    byte_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #22;
    checks++;
    if ({byte_ready, imem_we, imem_waddr, imem_wdata, words_loaded, core_start, done, err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h data=%h wl=%0d cs=%b done=%b err=%b, expected all 0",
               byte_ready, imem_we, imem_waddr, imem_wdata, words_loaded, core_start, done, err);
    end
    checks++;
    if (state_dbg !== HDR) begin
      failures++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, HDR);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (byte_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready_early: got %b expected 0", byte_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (byte_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready_after: got %b expected 1", byte_ready);
    end
  endtask

  task automatic test_single_word();
    wr_log.delete(); start_cnt = 0;
    frame_q = '{8'h01, 8'h8C, 8'h01, 8'h00, 8'h0A, 8'h87};
    model_frame();
    send_frame(2);
    checks++;
    if (timeouts != 0) begin failures++; $display("FAIL single_timeout: got %0d expected 0", timeouts); end
    checks++;
    if (wr_log.size() != exp_q.size()) begin
      failures++; $display("FAIL single_nwrites: got %0d expected %0d", wr_log.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (wr_log[i] !== exp_q[i]) begin failures++; $display("FAIL single_write%0d: got %h expected %h", i, wr_log[i], exp_q[i]); end
    end
    checks++;
    if ({done, err, words_loaded, byte_ready} !== {1'b1, 1'b0, 5'd1, 1'b0}) begin
      failures++; $display("FAIL single_status: got done=%b err=%b wl=%0d rdy=%b expected 1 0 1 0", done, err, words_loaded, byte_ready);
    end
    checks++;
    if (start_cnt !== 1 || core_start !== 1'b0) begin
      failures++; $display("FAIL single_start: got pulses=%0d level=%b expected 1 0", start_cnt, core_start);
    end
  endtask

  task automatic test_back_to_back();
    wr_log.delete(); start_cnt = 0; stall_cnt = 0;
    frame_q = '{8'h02, 8'h24, 8'h02, 8'h00, 8'h00, 8'h24, 8'h03, 8'h00, 8'h00, 8'h01};
    model_frame();
    send_frame(0);
    checks++;
    if (stall_cnt != 0 || timeouts != 0) begin
      failures++; $display("FAIL b2b_stall: got stalls=%0d timeouts=%0d expected 0 0", stall_cnt, timeouts);
    end
    checks++;
    if (wr_log.size() != exp_q.size()) begin
      failures++; $display("FAIL b2b_nwrites: got %0d expected %0d", wr_log.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (wr_log[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_write%0d: got %h expected %h", i, wr_log[i], exp_q[i]); end
    end
    checks++;
    if ({done, err, words_loaded} !== {1'b1, 1'b0, 5'd2} || start_cnt !== 1) begin
      failures++; $display("FAIL b2b_status: got done=%b err=%b wl=%0d starts=%0d expected 1 0 2 1", done, err, words_loaded, start_cnt);
    end
  endtask

  task automatic test_bad_checksum();
    wr_log.delete(); start_cnt = 0;
    frame_q = '{8'h01, 8'h8C, 8'h01, 8'h00, 8'h0A, 8'h86};
    model_frame();
    send_frame(1);
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== exp_q[0]) begin
      failures++; $display("FAIL badsum_write: got %0d writes expected 1 of %h", wr_log.size(), exp_q[0]);
    end
    checks++;
    if ({done, err, byte_ready} !== {exp_done, exp_err, 1'b0} || start_cnt !== 0) begin
      failures++; $display("FAIL badsum_status: got done=%b err=%b rdy=%b starts=%0d expected 0 1 0 0", done, err, byte_ready, start_cnt);
    end
  endtask

  task automatic test_bad_length();
    logic [7:0] hdrs[2];
    hdrs[0] = 8'h00;
    hdrs[1] = 8'h11;
    for (int k = 0; k < 2; k++) begin
      pulse_reload();
      wr_log.delete(); start_cnt = 0;
      frame_q = '{hdrs[k]};
      model_frame();
      send_frame(1);
      checks++;
      if ({done, err, byte_ready, words_loaded} !== {exp_done, exp_err, 1'b0, 5'd0} || wr_log.size() != 0) begin
        failures++; $display("FAIL badlen_%h: got done=%b err=%b rdy=%b wl=%0d writes=%0d expected 0 1 0 0 0",
                             hdrs[k], done, err, byte_ready, words_loaded, wr_log.size());
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    pulse_reload();
    wr_log.delete(); start_cnt = 0;
    random_frame(2, 1'b0);
    model_frame();
    for (int i = 0; i < 7; i++) send_byte(frame_q[i], 0, ok);
    byte_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({byte_ready, imem_we, imem_waddr, imem_wdata, words_loaded, core_start, done, err} !== '0 || state_dbg !== HDR) begin
      failures++;
      $display("FAIL midrst_async: got rdy=%b we=%b addr=%h data=%h wl=%0d done=%b err=%b st=%0d expected all 0",
               byte_ready, imem_we, imem_waddr, imem_wdata, words_loaded, done, err, state_dbg);
    end
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== exp_q[0]) begin
      failures++; $display("FAIL midrst_partial: got %0d writes expected 1 of %h", wr_log.size(), exp_q[0]);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    wr_log.delete(); start_cnt = 0;
    random_frame(1, 1'b0);
    model_frame();
    send_frame(2);
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== exp_q[0] || done !== 1'b1 || start_cnt !== 1) begin
      failures++; $display("FAIL midrst_fresh: got writes=%0d done=%b starts=%0d expected 1 write of %h, done 1, 1 start",
                           wr_log.size(), done, start_cnt, exp_q[0]);
    end
  endtask

  task automatic test_reload();
    int n;
    wr_log.delete(); start_cnt = 0;
    reload = 1'b1; byte_valid = 1'b1; byte_in = 8'h01;
    @(posedge clk); #1;
    reload = 1'b0; byte_valid = 1'b0;
    checks++;
    if (state_dbg !== HDR || {words_loaded, done, err, byte_ready} !== {5'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL reload_state: got st=%0d wl=%0d done=%b err=%b rdy=%b expected HDR 0 0 0 1",
                           state_dbg, words_loaded, done, err, byte_ready);
    end
    n = $urandom_range(1, DEPTH);
    random_frame(n, 1'b0);
    model_frame();
    send_frame(2);
    checks++;
    if (wr_log.size() != exp_q.size()) begin
      failures++; $display("FAIL reload_nwrites: got %0d expected %0d", wr_log.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (wr_log[i] !== exp_q[i]) begin failures++; $display("FAIL reload_write%0d: got %h expected %h", i, wr_log[i], exp_q[i]); end
    end
    checks++;
    if ({done, err, words_loaded} !== {exp_done, exp_err, exp_words} || start_cnt !== 1) begin
      failures++; $display("FAIL reload_status: got done=%b err=%b wl=%0d starts=%0d expected %b %b %0d 1",
                           done, err, words_loaded, start_cnt, exp_done, exp_err, exp_words);
    end
  endtask

  task automatic test_random_frames();
    int n;
    for (int t = 0; t < 8; t++) begin
      pulse_reload();
      wr_log.delete(); start_cnt = 0;
      n = $urandom_range(1, DEPTH);
      random_frame(n, ($urandom_range(0, 2) == 0));
      model_frame();
      send_frame(3);
      checks++;
      if (timeouts != 0) begin failures++; $display("FAIL rand%0d_timeout: got %0d expected 0", t, timeouts); end
      checks++;
      if (wr_log.size() != exp_q.size()) begin
        failures++; $display("FAIL rand%0d_nwrites: got %0d expected %0d", t, wr_log.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        checks++;
        if (wr_log[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_write%0d: got %h expected %h", t, i, wr_log[i], exp_q[i]); end
      end
      checks++;
      if ({done, err, words_loaded, byte_ready} !== {exp_done, exp_err, exp_words, 1'b0} || start_cnt !== int'(exp_done)) begin
        failures++; $display("FAIL rand%0d_status: got done=%b err=%b wl=%0d rdy=%b starts=%0d expected %b %b %0d 0 %0d",
                             t, done, err, words_loaded, byte_ready, start_cnt, exp_done, exp_err, exp_words, int'(exp_done));
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_word();
    pulse_reload();
    test_back_to_back();
    pulse_reload();
    test_bad_checksum();
    test_bad_length();
    test_reset_mid_frame();
    test_reload();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
